pipeline_stall_ctrl: RTL
========================

# pipeline_stall_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline with AES coprocessor.
- Merges three sources into one set of pipeline enables: load-use hazards, branch-operand hazards (branches resolve in ID) and multi-cycle AES coprocessor instructions.
- Owns the AES issue/wait state machine, including a watchdog timeout.
- Drives the PC, IF/ID and ID/EX pipeline-register controls directly.

## Interface

Parameters
- AES_TIMEOUT, 64 — max AES_WAIT cycles before abort; legal range 2..255.
- CNT_W, 32 — width of the stall-cycle counter (PERF_CNT_EN only).

Ports
- clk  in  1  — pipeline clock; all state updates on rising edge.
- rst  in  1  — synchronous, active-high reset.
- ifid_rs  in  5  — Rs of instruction in ID.
- ifid_rt  in  5  — Rt of instruction in ID.
- idex_rd  in  5  — destination register of instruction in EX.
- idex_mem_read  in  1  — EX instruction is a load.
- idex_reg_write  in  1  — EX instruction writes the register file.
- exmem_rd  in  5  — destination register of instruction in MEM.
- exmem_mem_read  in  1  — MEM instruction is a load.
- branch_id  in  1  — ID instruction is a branch.
- branch_taken  in  1  — ID branch resolved taken.
- aes_start  in  1  — ID instruction is an AES op.
- aes_done  in  1  — coprocessor completion pulse.
- pc_we  out  1  — PC write enable.
- ifid_we  out  1  — IF/ID register write enable.
- idex_bubble  out  1  — force NOP into ID/EX.
- ifid_flush  out  1  — zero IF/ID (taken branch).
- aes_go  out  1  — one-cycle coprocessor start.
- aes_err  out  1  — sticky timeout flag.
- stall_cycles  out  CNT_W  — present only with PERF_CNT_EN.

## Operation

Hazard terms are combinational. A match means `rd != 0` and `rd == ifid_rs || rd == ifid_rt`.
- lu = idex_mem_read && match(idex_rd)
- bx = branch_id && idex_reg_write && match(idex_rd)
- bm = branch_id && exmem_mem_read && match(exmem_rd)
- haz = lu | bx | bm

FSM states: RUN, AES_WAIT.
- **RUN**
  - If haz: pc_we=0, ifid_we=0, idex_bubble=1.
  - Else if aes_start: aes_go=1, no stall, next state AES_WAIT, timer cleared.
  - Else if branch_taken: ifid_flush=1.
  - Otherwise all enables are 1 and bubble/flush/go are 0.
- **AES_WAIT**
  - pc_we=0, ifid_we=0, idex_bubble=1 every cycle.
  - Hazard and branch inputs are ignored; aes_go=0.
  - On aes_done: next state RUN.
  - Else if the timer reaches AES_TIMEOUT-1: set aes_err, next state RUN.
  - Else the timer increments.
- Priority, highest first: rst > AES_WAIT > haz > aes_start > branch_taken.
- A stalled cycle never asserts ifid_flush or aes_go.
- aes_done while in RUN is ignored.
- aes_err is cleared only by rst.

## Timing

- Stall, flush and go outputs are Mealy: combinational from the current state and same-cycle inputs. No added latency.
- Load-use costs exactly 1 stall cycle. A branch depending on a load costs 2 (lu then bm).
- AES: issue cycle unstalled. AES_WAIT stalls N+1 cycles when aes_done arrives N cycles after entry; the aes_done cycle is still stalled. RUN resumes the next cycle.
- Timeout: at most AES_TIMEOUT stalled cycles. aes_err rises on the first RUN cycle.
- While rst=1 (regardless of state): pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0, aes_go=0. State is RUN after rst, timer=0, aes_err=0, stall_cycles=0.
- Reset during AES_WAIT abandons the wait; a late aes_done is then ignored.

## Configuration

- PERF_CNT_EN defined:
  - stall_cycles increments on each non-reset cycle with pc_we=0.
  - Saturates at all-ones.
  - Cleared by rst.
- PERF_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure

- Shared package mips_pkg holds:
  - the state enum (RUN, AES_WAIT)
  - REG_ZERO = 5'd0
  - the default AES_TIMEOUT constant.
- One sub-module, aes_wait_timer: clear/enable/terminal-count counter sized by $clog2(AES_TIMEOUT).

## Test plan

- idex_mem_read=1, idex_rd=8, ifid_rs=8 for 1 cycle -> pc_we=0, ifid_we=0, idex_bubble=1 that cycle only.
- Load to r9, then beq using r9: cycle 1 (lu) stalled, cycle 2 (bm, exmem_rd=9) stalled, cycle 3 branch_taken=1 -> ifid_flush=1.
- idex_rd=0, idex_mem_read=1, ifid_rs=0 -> no stall.
- aes_start=1, aes_done 5 cycles after entry -> aes_go pulse once, 6 stalled cycles, RUN next.
- AES_TIMEOUT=8, no aes_done -> 8 stalled cycles, then aes_err=1 held until rst.
- rst asserted in 3rd AES_WAIT cycle -> next cycle RUN, aes_err=0, stall_cycles=0 (PERF_CNT_EN); aes_done 2 cycles later has no effect.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;
  typedef enum logic {RUN, AES_WAIT} state_t;
  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         DEF_AES_TIMEOUT = 64;
endpackage

// File: rtl/aes_wait_timer.sv
// Watchdog counter for the AES wait: synchronous clear, count enable, terminal count at AES_TIMEOUT-1.
module aes_wait_timer
  import mips_pkg::*;
#(
  parameter int AES_TIMEOUT = DEF_AES_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int TW = (AES_TIMEOUT > 2) ? $clog2(AES_TIMEOUT) : 1;

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) r_cnt <= '0;
    else if (en)    r_cnt <= r_cnt + 1'b1;
  end

  assign tc = (r_cnt == TW'(AES_TIMEOUT - 1));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: merges load-use, branch-operand and AES-wait stalls into PC/IF/ID/ID/EX controls.
// Optional stall-cycle performance counter enabled by defining PERF_CNT_EN.
module pipeline_stall_ctrl
  import mips_pkg::*;
#(
  parameter int AES_TIMEOUT = DEF_AES_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic [4:0] idex_rd,
  input  logic       idex_mem_read,
  input  logic       idex_reg_write,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_mem_read,
  input  logic       branch_id,
  input  logic       branch_taken,
  input  logic       aes_start,
  input  logic       aes_done,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       aes_go,
  output logic       aes_err
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);
  state_t r_state, w_state_nxt;
  logic   r_aes_err;
  logic   w_lu, w_bx, w_bm, w_haz;
  logic   w_tmr_clr, w_tmr_en, w_tmr_tc, w_set_err;

  function automatic logic match(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return (rd != REG_ZERO) && ((rd == rs) || (rd == rt));
  endfunction

  assign w_lu  = idex_mem_read && match(idex_rd, ifid_rs, ifid_rt);
  assign w_bx  = branch_id && idex_reg_write && match(idex_rd, ifid_rs, ifid_rt);
  assign w_bm  = branch_id && exmem_mem_read && match(exmem_rd, ifid_rs, ifid_rt);
  assign w_haz = w_lu | w_bx | w_bm;

  aes_wait_timer #(.AES_TIMEOUT(AES_TIMEOUT)) u_tmr (
    .clk (clk),
    .rst (rst),
    .clr (w_tmr_clr),
    .en  (w_tmr_en),
    .tc  (w_tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_aes_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_set_err) r_aes_err <= 1'b1;
    end
  end

  // Mealy outputs; reset overrides every state so a held rst keeps the pipe frozen.
  always_comb begin
    w_state_nxt = r_state;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    aes_go      = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    w_set_err   = 1'b0;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_haz) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end else if (aes_start) begin
            aes_go      = 1'b1;
            w_tmr_clr   = 1'b1;
            w_state_nxt = AES_WAIT;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
        AES_WAIT: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          if (aes_done) begin
            w_state_nxt = RUN;
          end else if (w_tmr_tc) begin
            w_set_err   = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_tmr_en = 1'b1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign aes_err = r_aes_err;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst)                                    r_stall_cycles <= '0;
    else if (!pc_we && (r_stall_cycles != '1))  r_stall_cycles <= r_stall_cycles + 1'b1;
  end

  assign stall_cycles = r_stall_cycles;
`endif
endmodule
